// File: rtl/usb_pkg.sv
// Shared definitions for the USB endpoint buffer: owner-state encoding and default depth.
package usb_pkg;

    localparam int BUF_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_FILL   = 3'd1,
        RX_HOLD   = 3'd2,
        HOST_FILL = 3'd3,
        TX_DRAIN  = 3'd4
    } buf_state_t;

endpackage

// File: rtl/data_buffer_ram.sv
// DEPTH x 8 byte store: synchronous write, asynchronous (show-ahead) read.
module data_buffer_ram #(
    parameter int DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [7:0]               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [7:0]               o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_buffer_ctrl.sv
// Single shared packet buffer arbitrated between the USB RX/TX engines and the host.
// Ownership FSM decides which strobes are honoured; rejected strobes pulse access_conflict.
module usb_buffer_ctrl
    import usb_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   store_rx_packet_data,
    input  logic [7:0]             rx_packet_data,
    input  logic                   rx_packet_done,
    input  logic                   get_rx_data,
    output logic [7:0]             rx_data,
    input  logic                   store_tx_data,
    input  logic [7:0]             tx_data,
    input  logic                   get_tx_packet_data,
    output logic [7:0]             tx_packet_data,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] buffer_occupancy,
    output logic [2:0]             buf_state,
    output logic                   overrun,
    output logic                   underrun,
    output logic                   access_conflict
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = DEPTH[AW:0];

    buf_state_t  r_state;
    buf_state_t  w_state_next;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_occ;
    logic [AW:0]   w_occ_next;
    logic          r_overrun;
    logic          r_underrun;
    logic          r_conflict;

    logic       w_rx_wr;
    logic       w_tx_wr;
    logic       w_rx_pop;
    logic       w_tx_pop;
    logic       w_conflict;
    logic       w_full;
    logic       w_empty;
    logic       w_wr;
    logic       w_pop;
    logic [7:0] w_wdata;
    logic [7:0] w_rdata;

    assign w_full  = (r_occ == C_FULL);
    assign w_empty = (r_occ == '0);

    // Ownership decode: which strobe this state honours, everything else is a conflict.
    always_comb begin
        w_rx_wr    = 1'b0;
        w_tx_wr    = 1'b0;
        w_rx_pop   = 1'b0;
        w_tx_pop   = 1'b0;
        w_conflict = 1'b0;
        case (r_state)
            IDLE: begin
                if (store_rx_packet_data) begin
                    w_rx_wr    = 1'b1;
                    w_conflict = store_tx_data;
                end else begin
                    w_tx_wr = store_tx_data;
                end
                w_conflict = w_conflict | get_rx_data | get_tx_packet_data;
            end
            RX_FILL: begin
                w_rx_wr    = store_rx_packet_data;
                w_conflict = store_tx_data | get_rx_data | get_tx_packet_data;
            end
            RX_HOLD: begin
                w_rx_pop   = get_rx_data;
                w_conflict = store_rx_packet_data | store_tx_data | get_tx_packet_data;
            end
            HOST_FILL: begin
                if (get_tx_packet_data) begin
                    w_tx_pop   = 1'b1;
                    w_conflict = store_tx_data;
                end else begin
                    w_tx_wr = store_tx_data;
                end
                w_conflict = w_conflict | store_rx_packet_data | get_rx_data;
            end
            TX_DRAIN: begin
                w_tx_pop   = get_tx_packet_data;
                w_conflict = store_rx_packet_data | store_tx_data | get_rx_data;
            end
            default: begin
                w_conflict = 1'b0;
            end
        endcase
    end

    assign w_wr    = (w_rx_wr | w_tx_wr) & ~w_full;
    assign w_pop   = (w_rx_pop | w_tx_pop) & ~w_empty;
    assign w_wdata = w_rx_wr ? rx_packet_data : tx_data;

    always_comb begin
        w_occ_next = r_occ;
        if (w_wr) begin
            w_occ_next = r_occ + 1'b1;
        end else if (w_pop) begin
            w_occ_next = r_occ - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rx_wr) begin
                    w_state_next = RX_FILL;
                end else if (w_tx_wr) begin
                    w_state_next = HOST_FILL;
                end
            end
            RX_FILL: begin
                if (rx_packet_done) begin
                    w_state_next = (w_occ_next != '0) ? RX_HOLD : IDLE;
                end
            end
            RX_HOLD: begin
                if (w_pop && (w_occ_next == '0)) begin
                    w_state_next = IDLE;
                end
            end
            HOST_FILL: begin
                // Popping the only stored byte leaves nothing to drain.
                if (w_tx_pop) begin
                    w_state_next = (w_occ_next != '0) ? TX_DRAIN : IDLE;
                end
            end
            TX_DRAIN: begin
                if (w_pop && (w_occ_next == '0)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            r_conflict <= 1'b0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_occ      <= w_occ_next;
            r_conflict <= w_conflict;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if ((w_rx_wr | w_tx_wr) & w_full) begin
                r_overrun <= 1'b1;
            end
            // Any pop against an empty buffer is recorded, even one refused by ownership.
            if ((get_rx_data | get_tx_packet_data) & w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    data_buffer_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .i_clk  (clk),
        .i_we   (w_wr),
        .i_waddr(r_wptr),
        .i_wdata(w_wdata),
        .i_raddr(r_rptr),
        .o_rdata(w_rdata)
    );

    assign rx_data          = w_empty ? 8'h00 : w_rdata;
    assign tx_packet_data   = w_empty ? 8'h00 : w_rdata;
    assign buffer_occupancy = r_occ;
    assign buf_state        = r_state;
    assign overrun          = r_overrun;
    assign underrun         = r_underrun;
    assign access_conflict  = r_conflict;

endmodule
